// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide execute unit. It sits beside the
// single-cycle ALU behind a valid/ready handshake, and the core stalls on
// in_ready / out_valid. funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU,
// REM or REMU.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   kill       synchronous abort of any in-flight operation (highest priority)
//   in_valid   op/op1/op2 valid this cycle
//   in_ready   unit can accept an operation (IDLE only)
//   op         funct3 of the M-extension instruction
//   op1, op2   rs1 / rs2 values
//   out_valid  result valid; held until out_ready
//   out_ready  consumer takes the result
//   result     operation result
//   zero       result == 0 (meaningful only with out_valid)
//
// Optional build macro
//   MULDIV_EARLY_OUT_EN : multiply CALC stops as soon as the remaining
//   multiplier bits are all zero (minimum one iteration). Division timing
//   and every result are unchanged. Undefined: multiply always runs 32
//   iterations.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_res_q, neg_res_d;   // product / quotient needs negating
  logic                neg_rem_q, neg_rem_d;   // dividend was negative
  logic [2*XLEN-1:0]   mcand_q, mcand_d;       // multiplicand, or divisor in [XLEN-1:0]
  logic [XLEN-1:0]     mplier_q, mplier_d;     // multiplier, or dividend/quotient
  logic [2*XLEN-1:0]   acc_q, acc_d;           // product, or partial remainder in [XLEN-1:0]
  logic [5:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;

  // ---------------------------------------------------------------------------
  // Operand decode for the accept cycle
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  // MULH, MULHSU, DIV, REM read op1 as signed; only MULH, DIV, REM read op2 so.
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg    = a_signed & op1[XLEN-1];
  assign b_neg    = b_signed & op2[XLEN-1];
  assign a_mag    = a_neg ? (~op1 + 1'b1) : op1;
  assign b_mag    = b_neg ? (~op2 + 1'b1) : op2;

  assign div_zero = (op2 == '0);
  assign div_ovf  = op[2] && !op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  // Short-circuit results; op[1] distinguishes REM* from DIV*.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? op1 : '1;
    end else begin
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath steps
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_trial;
  logic              mul_last;

  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // {rem, quot} << 1: the quotient register's MSB feeds the remainder LSB.
  assign rem_shift = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
  assign rem_trial = rem_shift - {1'b0, mcand_q[XLEN-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
  // This iteration consumes bit 0; stop if nothing above it remains.
  assign mul_last = (mplier_q[XLEN-1:1] == '0) || (cnt_q == LAST_ITER);
`else
  assign mul_last = (cnt_q == LAST_ITER);
`endif

  // Sign correction and result select for the FIX cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res_fix;

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = neg_res_q ? (~mplier_q + 1'b1) : mplier_q;
  assign rem_fix  = neg_rem_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];

  always_comb begin
    res_fix = '0;
    if (op_q[2]) begin
      res_fix = op_q[1] ? rem_fix : quot_fix;
    end else if (op_q[1:0] == 2'b00) begin
      res_fix = prod_fix[XLEN-1:0];
    end else begin
      res_fix = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !kill) begin
          op_d      = op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          acc_d     = '0;
          if (op[2]) begin
            mcand_d  = {{XLEN{1'b0}}, b_mag};
            mplier_d = a_mag;
          end else begin
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
          end
          if (op[2] && (div_zero || div_ovf)) begin
            result_d = special_res;
            zero_d   = (special_res == '0);
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (!op_q[2]) begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mul_last) begin
            state_d = S_FIX;
          end
        end else begin
          // Restoring step: keep the difference only when it did not borrow.
          if (!rem_trial[XLEN]) begin
            acc_d    = {{XLEN{1'b0}}, rem_trial[XLEN-1:0]};
            mplier_d = {mplier_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d    = {{XLEN{1'b0}}, rem_shift[XLEN-1:0]};
            mplier_d = {mplier_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        result_d = res_fix;
        zero_d   = (res_fix == '0);
        state_d  = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Scoreboard bench for muldiv_unit. The driver pushes the reference result
// and expected latency at each accept; an independent monitor pops and
// compares whenever out_valid first appears, and checks hold/handshake rules.
// Honors MULDIV_EARLY_OUT_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kill = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain 64-bit arithmetic on the architectural definitions
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb_;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    p   = 64'd0;
    r   = 32'd0;
    case (f)
      3'd0: begin p = ua * ub;  r = p[31:0];  end
      3'd1: begin p = sa * sb_; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      3'd4: begin if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = sa / sb_; r = p[31:0]; end end
      3'd5: begin if (b == 32'd0) r = 32'hFFFFFFFF; else r = a / b; end
      3'd6: begin if (b == 32'd0) r = a; else begin p = sa % sb_; r = p[31:0]; end end
      default: begin if (b == 32'd0) r = a; else r = a % b; end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          k;
    logic [31:0] m;
    k = 32;
    m = b;
    if (f[2]) begin
      if (b == 32'd0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (f == 3'd1 && b[31]) m = -b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`endif
    return 2 + k;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver helpers (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int   w;
    exp_t e;
    op = f; op1 = a; op2 = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stuck low, op %0d", f);
    end else if (push) begin
      e.res = ref_res(f, a, b);
      e.acc_cyc = cyc;
      e.lat = ref_lat(f, a, b);
      e.op = f; e.a = a; e.b = b;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    op1 = $urandom;
    op2 = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while ((sb.size() != 0 || !in_ready) && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0 || !in_ready) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, in_ready %b", sb.size(), in_ready);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return $urandom & 32'h0000FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------------------------------------------------------------------
  // Monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  bit          seen = 1'b0;
  bit          xfer = 1'b0;
  logic [31:0] held = 32'd0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0;
      xfer = 1'b0;
    end else begin
      if (xfer) begin
        chk("ready_after_xfer", 32'(in_ready), 32'd1);
        chk("valid_drop_after_xfer", 32'(out_valid), 32'd0);
        xfer = 1'b0;
        seen = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          n_out++;
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: result %h with nothing outstanding", result);
          end else begin
            e = sb.pop_front();
            chk($sformatf("result op%0d %h,%h", e.op, e.a, e.b), result, e.res);
            chk($sformatf("zero op%0d", e.op), 32'(zero), 32'(e.res == 32'd0));
            chk($sformatf("latency op%0d %h,%h", e.op, e.a, e.b), 32'(cyc - e.acc_cyc), 32'(e.lat));
          end
          held = result;
          seen = 1'b1;
        end else begin
          chk("result_hold", result, held);
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready && !kill) xfer = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values
    issue(3'd0, 32'd7, 32'd6, 1'b1);
    issue(3'd1, 32'h80000000, 32'h80000000, 1'b1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 1'b1);
    issue(3'd6, 32'd5, 32'd0, 1'b1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle(200);

    // Consumer stall in DONE for 10 cycles
    out_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("stall_reached_done", 32'(out_valid), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_released", 32'(out_valid), 32'd0);
    wait_idle(50);

    // kill at CALC iteration 10, then kill overriding an IDLE accept
    n0 = n_out;
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_to_idle", 32'(in_ready), 32'd1);
    kill = 1'b1; in_valid = 1'b1; op = 3'd5; op1 = 32'd5; op2 = 32'd0;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    chk("kill_blocks_accept", 32'(in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("kill_no_output", 32'(n_out), 32'(n0));

    // Asynchronous reset in the middle of CALC
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd3, 1'b1);
    wait_idle(100);

    // Randomized traffic with a random consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b1);
    end
    wait_idle(3000);
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d results outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit. Takes the same op1/op2 operand pair as the single-cycle ALU and returns a result with a zero flag.
- Multi-cycle, so it sits beside the ALU behind a valid/ready handshake. The core stalls on in_ready/out_valid.
- Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, selected by funct3.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- kill  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept an operation (high only in IDLE).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  input  XLEN  rs1 value.
- op2  input  XLEN  rs2 value.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  operation result.
- zero  output  1  high when result == 0; valid only with out_valid.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept occurs when in_valid & in_ready.
  - On accept, latch op, the sign flags and the operand magnitudes. Signedness per RISC-V: MULHSU treats op1 as signed and op2 as unsigned.
  - Division special cases go IDLE->DONE, so out_valid is high 1 cycle after accept:
    - divisor == 0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op1.
    - signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF, DIV/REM): DIV result = 0x80000000; REM result = 0.
  - Otherwise go to CALC with iteration counter = 0.
- CALC, multiply:
  - Shift-add on a 64-bit product: if multiplier bit 0 is set, product += multiplicand.
  - Then multiplicand <<= 1 and multiplier >>= 1.
  - Runs exactly 32 iterations (see Optional Feature), one per cycle.
- CALC, divide:
  - Restoring division, one quotient bit per cycle.
  - Each cycle: shift {rem, quot} left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and set the quotient LSB accordingly.
  - Always 32 iterations.
- FIX (1 cycle):
  - Apply sign correction: two's-complement negate the product if the operand signs differ. Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Select the result: low 32 bits for MUL, high 32 bits for MULH*, quotient for DIV*, remainder for REM*.
  - Register result and zero; go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - result and zero are stable until out_valid & out_ready; that transfer returns the unit to IDLE.
  - in_ready rises the cycle after the transfer; no same-cycle back-to-back accept.
- Latency: accept edge to first out_valid = 34 cycles (1 setup + 32 CALC + 1 FIX); 1 cycle for division special cases.
- kill:
  - When high, the next state is IDLE and out_valid drops, regardless of state. kill has priority over accept and over the output transfer.
  - In IDLE, a kill with in_valid high does not accept.
- All arithmetic is modulo 2^64 internally and modulo 2^32 at the output. No exceptions are raised.
- Inputs are ignored outside an accepting IDLE cycle.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply CALC ends when the shifted multiplier register reaches 0, with a minimum of 1 iteration.
  - Latency = 2 + k, where k = max(1, index of the highest set bit of the multiplier magnitude + 1). Example: op2=5 gives k=3, so latency 5.
  - Division is unchanged.
- Undefined: multiply always runs 32 iterations; latency is fixed at 34.
- Results are identical either way.

Test Plan:
- MUL op1=7, op2=6, out_ready=1 -> out_valid 34 cycles after accept (5 with the feature), result=42, zero=0; in_ready high the following cycle.
- MULH op1=0x80000000, op2=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0, zero=1.
- out_ready held low 10 cycles in DONE -> result and out_valid stable throughout, in_ready=0; transfer on the first out_ready cycle.
- kill asserted at CALC iteration 10 -> IDLE next cycle, no out_valid. rst pulsed mid-CALC -> outputs immediately at reset values; a new MUL 3x3 then returns 9.
